// File: rtl/ucsbece154a_memarb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154a_memarb_if
//  Description : Bundle of the two master request ports and the shared
//                memory port seen by the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ucsbece154a_memarb_if;
    // Port 0 (core)
    logic        p0_req_i;
    logic        p0_we_i;
    logic [31:0] p0_a_i;
    logic [31:0] p0_wd_i;
    logic        p0_gnt_o;
    logic [31:0] p0_rd_o;
    // Port 1 (debug/loader)
    logic        p1_req_i;
    logic        p1_we_i;
    logic [31:0] p1_a_i;
    logic [31:0] p1_wd_i;
    logic        p1_gnt_o;
    logic [31:0] p1_rd_o;
    // Shared memory port
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    // Arbiter view
    modport slave (
        input  p0_req_i, p0_we_i, p0_a_i, p0_wd_i,
        output p0_gnt_o, p0_rd_o,
        input  p1_req_i, p1_we_i, p1_a_i, p1_wd_i,
        output p1_gnt_o, p1_rd_o,
        output mem_we_o, mem_a_o, mem_wd_o,
        input  mem_rd_i
    );

    // Masters-and-memory view
    modport master (
        output p0_req_i, p0_we_i, p0_a_i, p0_wd_i,
        input  p0_gnt_o, p0_rd_o,
        output p1_req_i, p1_we_i, p1_a_i, p1_wd_i,
        input  p1_gnt_o, p1_rd_o,
        input  mem_we_o, mem_a_o, mem_wd_o,
        output mem_rd_i
    );
endinterface
`default_nettype wire

// File: rtl/ucsbece154a_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154a_memarb
//  Description : Two-port round-robin memory arbiter with bounded bursts,
//                sharing one combinational-read memory between the core
//                (port 0) and a debug/loader master (port 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154a_memarb #(
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    ucsbece154a_memarb_if.slave         bus
);

    localparam int                 c_cnt_w = $clog2(MAX_BURST) + 1;
    localparam logic [c_cnt_w:0]   c_max   = (c_cnt_w + 1)'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last;     // last port to lose ownership by burst limit
    logic [c_cnt_w-1:0]   r_cnt;      // grants taken in the current tenure

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic [c_cnt_w:0]     w_cnt_nxt;
    logic                 w_more;

    // Grants are qualified by reset so nothing is performed in a reset cycle
    assign w_gnt0 = (r_state == S_OWN0) & bus.p0_req_i & ~reset;
    assign w_gnt1 = (r_state == S_OWN1) & bus.p1_req_i & ~reset;

    assign bus.p0_gnt_o = w_gnt0;
    assign bus.p1_gnt_o = w_gnt1;

    // Read data is broadcast; only the granted port consumes it
    assign bus.p0_rd_o = bus.mem_rd_i;
    assign bus.p1_rd_o = bus.mem_rd_i;

    // Burst accounting: another grant still fits in the current tenure
    assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
    assign w_more    = (w_cnt_nxt < c_max);

    // Steer the owner's access onto the memory port; idle drives zeros
    always_comb begin
        bus.mem_we_o = 1'b0;
        bus.mem_a_o  = 32'd0;
        bus.mem_wd_o = 32'd0;
        case (r_state)
            S_OWN0: begin
                bus.mem_a_o  = bus.p0_a_i;
                bus.mem_wd_o = bus.p0_wd_i;
                bus.mem_we_o = w_gnt0 & bus.p0_we_i;
            end
            S_OWN1: begin
                bus.mem_a_o  = bus.p1_a_i;
                bus.mem_wd_o = bus.p1_wd_i;
                bus.mem_we_o = w_gnt1 & bus.p1_we_i;
            end
            default: ;
        endcase
    end

    // Ownership FSM with burst limit and round-robin tie-break
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.p0_req_i && bus.p1_req_i)
                        r_state <= r_last ? S_OWN0 : S_OWN1;
                    else if (bus.p0_req_i)
                        r_state <= S_OWN0;
                    else if (bus.p1_req_i)
                        r_state <= S_OWN1;
                end
                S_OWN0: begin
                    if (bus.p0_req_i) begin
                        if (w_more) begin
                            r_cnt <= w_cnt_nxt[c_cnt_w-1:0];
                        end else if (bus.p1_req_i) begin
                            r_state <= S_OWN1;
                            r_cnt   <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= bus.p1_req_i ? S_OWN1 : S_IDLE;
                    end
                end
                S_OWN1: begin
                    if (bus.p1_req_i) begin
                        if (w_more) begin
                            r_cnt <= w_cnt_nxt[c_cnt_w-1:0];
                        end else if (bus.p0_req_i) begin
                            r_state <= S_OWN0;
                            r_cnt   <= '0;
                            r_last  <= 1'b1;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= bus.p0_req_i ? S_OWN0 : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucsbece154a_memarb
//  Description : Self-checking bench for the two-port memory arbiter with a
//                behavioural ownership/memory model and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece154a_memarb;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    ucsbece154a_memarb_if bus ();

    ucsbece154a_memarb #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter: combinational read, clocked write
    logic [31:0] mem [0:255];
    always @(posedge clk) if (bus.mem_we_o) mem[bus.mem_a_o[9:2]] <= bus.mem_wd_o;
    assign bus.mem_rd_i = mem[bus.mem_a_o[9:2]];

    // Reference model: owner (-1 = nobody), grants used in tenure, last loser
    int          own;
    int          used;
    int          last_loser;
    logic [31:0] ref_mem [0:255];

    // Expected / observed values of the current cycle
    logic        e_g0, e_g1, e_we;
    logic [31:0] e_a, e_wd;
    logic        o_g0, o_g1, o_we;

    int n_chk  = 0;
    int n_fail = 0;
    int wait0, wait1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model, away from the clock edge
    task automatic check_cycle();
        e_g0 = (own == 0) && bus.p0_req_i && !reset;
        e_g1 = (own == 1) && bus.p1_req_i && !reset;
        e_we = (e_g0 && bus.p0_we_i) || (e_g1 && bus.p1_we_i);
        e_a  = (own == 0) ? bus.p0_a_i  : (own == 1) ? bus.p1_a_i  : 32'd0;
        e_wd = (own == 0) ? bus.p0_wd_i : (own == 1) ? bus.p1_wd_i : 32'd0;
        o_g0 = bus.p0_gnt_o;
        o_g1 = bus.p1_gnt_o;
        o_we = bus.mem_we_o;
        chk("gnt0", {31'd0, o_g0}, {31'd0, e_g0});
        chk("gnt1", {31'd0, o_g1}, {31'd0, e_g1});
        chk("mem_we", {31'd0, o_we}, {31'd0, e_we});
        chk("mem_a", bus.mem_a_o, e_a);
        chk("mem_wd", bus.mem_wd_o, e_wd);
        if (e_g0 && !bus.p0_we_i) chk("p0_rd", bus.p0_rd_o, ref_mem[bus.p0_a_i[9:2]]);
        if (e_g1 && !bus.p1_we_i) chk("p1_rd", bus.p1_rd_o, ref_mem[bus.p1_a_i[9:2]]);
    endtask

    // Advance the model by the ownership rules at the clock edge
    task automatic model_update();
        int  x, o;
        logic rx, ro;
        if (e_we) ref_mem[e_a[9:2]] = e_wd;
        if (reset) begin
            own = -1; used = 0; last_loser = 1;
        end else if (own < 0) begin
            used = 0;
            if (bus.p0_req_i && bus.p1_req_i) own = 1 - last_loser;
            else if (bus.p0_req_i)            own = 0;
            else if (bus.p1_req_i)            own = 1;
        end else begin
            x  = own;
            o  = 1 - own;
            rx = (x == 0) ? bus.p0_req_i : bus.p1_req_i;
            ro = (o == 0) ? bus.p0_req_i : bus.p1_req_i;
            if (rx) begin
                if (used + 1 < MB) used++;
                else begin
                    used = 0;
                    if (ro) begin own = o; last_loser = x; end
                end
            end else begin
                used = 0;
                own  = ro ? o : -1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req_i = req; bus.p0_we_i = we; bus.p0_a_i = a; bus.p0_wd_i = wd;
        end else begin
            bus.p1_req_i = req; bus.p1_we_i = we; bus.p1_a_i = a; bus.p1_wd_i = wd;
        end
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = i * 32'h0101_0101;
            ref_mem[i] = i * 32'h0101_0101;
        end
        own = -1; used = 0; last_loser = 1;
        wait0 = 0; wait1 = 0;

        // Reset held 2 cycles with both ports requesting
        drive(0, 1'b1, 1'b1, 32'h10, 32'hA0A0_A0A0);
        drive(1, 1'b1, 1'b1, 32'h14, 32'hB0B0_B0B0);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("rst_gnt0", {31'd0, o_g0}, 32'd0);
            chk("rst_gnt1", {31'd0, o_g1}, 32'd0);
            chk("rst_we", {31'd0, o_we}, 32'd0);
        end
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'd0);
        cycle();
        chk("post_rst_idle", {30'd0, o_g1, o_g0}, 32'd0);
        cycle();
        chk("first_gnt_p0", {30'd0, o_g1, o_g0}, 32'd1);

        // Single write then read on port 0
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        cycle();
        chk("wr_wait", {31'd0, o_g0}, 32'd0);
        cycle();
        chk("wr_gnt", {31'd0, o_g0}, 32'd1);
        drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        chk("rd_data", bus.p0_rd_o, 32'hDEAD_BEEF);
        cycle();
        chk("rd_gnt", {31'd0, o_g0}, 32'd1);
        chk("rd_no_p1", {31'd0, o_g1}, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();

        // Contention: 0,0,0,0,1,1,1,1,... after one idle cycle
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k == 0) chk("cont_idle", {30'd0, o_g1, o_g0}, 32'd0);
            else chk("cont_pattern", {30'd0, o_g1, o_g0},
                     (((k - 1) / MB) % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Uncontended burst on port 1: no gaps past the burst limit
        do_reset();
        drive(1, 1'b1, 1'b0, 32'h24, 32'd0);
        for (int k = 0; k < 11; k++) begin
            cycle();
            chk("solo_p1", {30'd0, o_g1, o_g0}, (k >= 1) ? 32'd2 : 32'd0);
        end

        // Early release by port 0 while port 1 waits
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
        cycle(); cycle(); cycle();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        chk("rel_bubble", {30'd0, o_g1, o_g0}, 32'd0);
        cycle();
        chk("rel_p1", {30'd0, o_g1, o_g0}, 32'd2);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
        cycle();
        cycle();
        chk("rel_tie_p0", {30'd0, o_g1, o_g0}, 32'd1);

        // Reset landing on a granted write
        do_reset();
        drive(1, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        cycle();
        reset = 1'b1;
        cycle();
        chk("rstwr_we", {31'd0, o_we}, 32'd0);
        chk("rstwr_gnt", {31'd0, o_g1}, 32'd0);
        reset = 1'b0;
        cycle();
        chk("rstwr_idle", {30'd0, o_g1, o_g0}, 32'd0);
        chk("rstwr_mem", mem[32], 32'h2020_2020);
        cycle();
        chk("rstwr_regnt", {31'd0, o_g1}, 32'd1);

        // Random traffic obeying the requester hold rule
        do_reset();
        for (int k = 0; k < 600; k++) begin
            cycle();
            if (bus.p0_req_i) begin
                wait0 = e_g0 ? 0 : wait0 + 1;
                chk("wait0", {31'd0, wait0 <= MB + 1}, 32'd1);
            end
            if (bus.p1_req_i) begin
                wait1 = e_g1 ? 0 : wait1 + 1;
                chk("wait1", {31'd0, wait1 <= MB + 1}, 32'd1);
            end
            if (!bus.p0_req_i || e_g0) begin
                drive(0, $urandom_range(0, 3) != 0, 1'($urandom),
                      {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
                wait0 = 0;
            end
            if (!bus.p1_req_i || e_g1) begin
                drive(1, $urandom_range(0, 3) != 0, 1'($urandom),
                      {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
                wait1 = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
